// File: rtl/regfile_pkg.sv
// Shared constants and FSM encoding for the scoreboarded register file.
package regfile_pkg;
   localparam int XLEN_DEF = 32;
   localparam int NREG_DEF = 32;
   localparam int NRP_DEF  = 2;

   typedef enum logic {
      ST_IDLE  = 1'b0,
      ST_CLEAR = 1'b1
   } rf_state_e;
endpackage

// File: rtl/regfile_sb_if.sv
// Writeback, issue, read and sweep-clear signals of the register file.
interface regfile_sb_if
   import regfile_pkg::*;
#(
   parameter int XLEN = XLEN_DEF,
   parameter int NREG = NREG_DEF,
   parameter int NRP  = NRP_DEF,
   localparam int AW  = $clog2(NREG)
) ();
   logic                           wr_en;
   logic [AW-1:0]                  wr_addr;
   logic [XLEN-1:0]                wr_data;
   logic [NRP-1:0]                 rd_en;
   logic [NRP-1:0][AW-1:0]         rd_addr;
   logic [NRP-1:0][XLEN-1:0]       rd_data;
   logic [NRP-1:0]                 rd_busy;
   logic                           iss_en;
   logic [AW-1:0]                  iss_addr;
   logic                           clr_req;
   logic                           clr_busy;

   modport master (
      output wr_en, wr_addr, wr_data, rd_en, rd_addr, iss_en, iss_addr, clr_req,
      input  rd_data, rd_busy, clr_busy
   );

   modport slave (
      input  wr_en, wr_addr, wr_data, rd_en, rd_addr, iss_en, iss_addr, clr_req,
      output rd_data, rd_busy, clr_busy
   );
endinterface

// File: rtl/regfile_rd_port.sv
// One combinational read port: array mux, x0 forced to zero, write-through bypass, busy.
module regfile_rd_port #(
   parameter int XLEN = 32,
   parameter int NREG = 32,
   localparam int AW  = $clog2(NREG)
) (
   input  logic                       rd_en,
   input  logic [AW-1:0]              rd_addr,
   input  logic [NREG-1:0][XLEN-1:0]  regs,
   input  logic [NREG-1:0]            pending,
   input  logic                       wr_en,
   input  logic [AW-1:0]              wr_addr,
   input  logic [XLEN-1:0]            wr_data,
   input  logic                       clearing,
   output logic [XLEN-1:0]            rd_data,
   output logic                       rd_busy
);
   logic nz;
   logic hit;

   always_comb begin
      nz      = (rd_addr != '0);
      hit     = wr_en && nz && (wr_addr == rd_addr);
      rd_data = '0;
      if (rd_en && nz) rd_data = hit ? wr_data : regs[rd_addr];
      // during a sweep every enabled read stalls regardless of address
      if (clearing) rd_busy = rd_en;
      else          rd_busy = rd_en && nz && pending[rd_addr] && !hit;
   end
endmodule

// File: rtl/regfile_sb.sv
// Register file with pending-bit scoreboard and a one-register-per-cycle sweep clear.
module regfile_sb
   import regfile_pkg::*;
#(
   parameter int XLEN = XLEN_DEF,
   parameter int NREG = NREG_DEF,
   parameter int NRP  = NRP_DEF,
   localparam int AW  = $clog2(NREG)
) (
   input  logic          clk,
   input  logic          reset,
   regfile_sb_if.slave   bus
);
   logic [NREG-1:0][XLEN-1:0] regs;
   logic [NREG-1:0]           pending;
   rf_state_e                 state;
   logic [AW-1:0]             clr_cnt;
   logic                      clr_busy_q;
   logic                      idle;
   logic                      wr_eff;

   assign idle         = (state == ST_IDLE);
   assign wr_eff       = bus.wr_en && idle;
   assign bus.clr_busy = clr_busy_q;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state      <= ST_IDLE;
         clr_cnt    <= AW'(1);
         clr_busy_q <= 1'b0;
         regs       <= '0;
         pending    <= '0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (bus.wr_en && bus.wr_addr != '0) begin
                  regs[bus.wr_addr]    <= bus.wr_data;
                  pending[bus.wr_addr] <= 1'b0;
               end
               // later assignment: issue beats writeback on the same address
               if (bus.iss_en && bus.iss_addr != '0)
                  pending[bus.iss_addr] <= 1'b1;
               if (bus.clr_req) begin
                  state      <= ST_CLEAR;
                  clr_busy_q <= 1'b1;
                  clr_cnt    <= AW'(1);
               end
            end
            ST_CLEAR: begin
               regs[clr_cnt]    <= '0;
               pending[clr_cnt] <= 1'b0;
               if (clr_cnt == AW'(NREG-1)) begin
                  state      <= ST_IDLE;
                  clr_busy_q <= 1'b0;
                  clr_cnt    <= AW'(1);
               end else begin
                  clr_cnt <= clr_cnt + AW'(1);
               end
            end
         endcase
      end
   end

   for (genvar k = 0; k < NRP; k++) begin : g_rd
      regfile_rd_port #(.XLEN(XLEN), .NREG(NREG)) u_rd (
         .rd_en    (bus.rd_en[k]),
         .rd_addr  (bus.rd_addr[k]),
         .regs     (regs),
         .pending  (pending),
         .wr_en    (wr_eff),
         .wr_addr  (bus.wr_addr),
         .wr_data  (bus.wr_data),
         .clearing (!idle),
         .rd_data  (bus.rd_data[k]),
         .rd_busy  (bus.rd_busy[k])
      );
   end
endmodule

// File: tb/tb_regfile_sb.sv
// Directed bench for regfile_sb: default build plus a 4-port 64-bit build.
module tb_regfile_sb;
   logic clk;
   logic reset;
   int   n_chk = 0;
   int   n_bad = 0;
   int   n_cyc;

   regfile_sb_if #(.XLEN(32), .NREG(32), .NRP(2)) bus_a ();
   regfile_sb_if #(.XLEN(64), .NREG(32), .NRP(4)) bus_b ();

   regfile_sb #(.XLEN(32), .NREG(32), .NRP(2)) dut_a (.clk(clk), .reset(reset), .bus(bus_a));
   regfile_sb #(.XLEN(64), .NREG(32), .NRP(4)) dut_b (.clk(clk), .reset(reset), .bus(bus_b));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h want %0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_a();
      bus_a.wr_en = 0; bus_a.wr_addr = '0; bus_a.wr_data = '0;
      bus_a.rd_en = '0; bus_a.rd_addr = '0;
      bus_a.iss_en = 0; bus_a.iss_addr = '0; bus_a.clr_req = 0;
   endtask

   task automatic fill_a(input int lo, input int hi);
      for (int i = lo; i <= hi; i++) begin
         bus_a.wr_en = 1; bus_a.wr_addr = 5'(i); bus_a.wr_data = 32'h1000 + i;
         bus_a.iss_en = (i == 12); bus_a.iss_addr = 5'(i);
         step();
      end
      idle_a();
   endtask

   initial begin
      reset = 0;
      idle_a();
      bus_b.wr_en = 0; bus_b.wr_addr = '0; bus_b.wr_data = '0;
      bus_b.rd_en = '0; bus_b.rd_addr = '0;
      bus_b.iss_en = 0; bus_b.iss_addr = '0; bus_b.clr_req = 0;
      #12;
      chk("rst_rd_data", 64'(bus_a.rd_data), 0);
      chk("rst_rd_busy", 64'(bus_a.rd_busy), 0);
      chk("rst_clr_busy", 64'(bus_a.clr_busy), 0);
      reset = 1;
      step();

      // write then read x5; x0 write ignored
      bus_a.wr_en = 1; bus_a.wr_addr = 5; bus_a.wr_data = 32'hDEADBEEF;
      step();
      idle_a();
      bus_a.rd_en = 2'b01; bus_a.rd_addr[0] = 5; #1;
      chk("rd_x5", 64'(bus_a.rd_data[0]), 64'hDEADBEEF);
      bus_a.rd_en = 2'b00; #1;
      chk("rd_en_off", 64'(bus_a.rd_data[0]), 0);
      bus_a.wr_en = 1; bus_a.wr_addr = 0; bus_a.wr_data = 32'h1;
      bus_a.rd_en = 2'b01; bus_a.rd_addr[0] = 0; #1;
      chk("x0_no_bypass", 64'(bus_a.rd_data[0]), 0);
      step();
      bus_a.wr_en = 0; #1;
      chk("x0_reads_zero", 64'(bus_a.rd_data[0]), 0);

      // same-cycle write-through on port 1
      idle_a();
      bus_a.wr_en = 1; bus_a.wr_addr = 7; bus_a.wr_data = 32'h12345678;
      bus_a.rd_en = 2'b10; bus_a.rd_addr[1] = 7; #1;
      chk("bypass_data", 64'(bus_a.rd_data[1]), 64'h12345678);
      chk("bypass_busy", 64'(bus_a.rd_busy[1]), 0);
      step();
      bus_a.wr_en = 0; #1;
      chk("x7_after", 64'(bus_a.rd_data[1]), 64'h12345678);

      // issue x3, stall, writeback releases it
      idle_a();
      bus_a.iss_en = 1; bus_a.iss_addr = 3;
      step();
      bus_a.iss_en = 0;
      bus_a.rd_en = 2'b01; bus_a.rd_addr[0] = 3; #1;
      chk("x3_busy", 64'(bus_a.rd_busy[0]), 1);
      bus_a.wr_en = 1; bus_a.wr_addr = 3; bus_a.wr_data = 32'hA5; #1;
      chk("x3_byp_busy", 64'(bus_a.rd_busy[0]), 0);
      chk("x3_byp_data", 64'(bus_a.rd_data[0]), 64'hA5);
      step();
      bus_a.wr_en = 0; #1;
      chk("x3_rel_busy", 64'(bus_a.rd_busy[0]), 0);
      chk("x3_rel_data", 64'(bus_a.rd_data[0]), 64'hA5);

      // issue and writeback same edge: set wins
      idle_a();
      bus_a.iss_en = 1; bus_a.iss_addr = 9;
      bus_a.wr_en = 1; bus_a.wr_addr = 9; bus_a.wr_data = 32'h99;
      step();
      idle_a();
      bus_a.rd_en = 2'b10; bus_a.rd_addr[1] = 9; #1;
      chk("x9_busy", 64'(bus_a.rd_busy[1]), 1);
      chk("x9_data", 64'(bus_a.rd_data[1]), 64'h99);

      // full fill then sweep; writes, issues and clr_req during sweep are ignored
      idle_a();
      fill_a(1, 31);
      bus_a.rd_en = 2'b01; bus_a.rd_addr[0] = 31; #1;
      chk("fill_x31", 64'(bus_a.rd_data[0]), 64'h101F);
      idle_a();
      bus_a.iss_en = 1; bus_a.iss_addr = 20;
      bus_a.clr_req = 1;
      step();
      idle_a();
      bus_a.rd_en = 2'b11; bus_a.rd_addr[0] = 1; bus_a.rd_addr[1] = 9;
      n_cyc = 0;
      for (int c = 1; c <= 60; c++) begin
         if (!bus_a.clr_busy) break;
         n_cyc++;
         if (c == 5) begin
            chk("clr_rd_busy", 64'(bus_a.rd_busy), 64'h3);
            bus_a.clr_req = 1;
         end
         if (c == 6) bus_a.clr_req = 0;
         if (c == 10) begin
            bus_a.wr_en = 1; bus_a.wr_addr = 2; bus_a.wr_data = 32'hFFFF;
            bus_a.iss_en = 1; bus_a.iss_addr = 2;
         end
         if (c == 11) begin
            bus_a.wr_en = 0; bus_a.iss_en = 0;
         end
         step();
      end
      chk("clr_cycles", 64'(n_cyc), 31);
      idle_a();
      step();
      chk("clr_no_retrig", 64'(bus_a.clr_busy), 0);
      for (int i = 0; i < 32; i++) begin
         bus_a.rd_en = 2'b11; bus_a.rd_addr[0] = 5'(i); bus_a.rd_addr[1] = 5'(i); #1;
         chk($sformatf("swept_x%0d", i),
             64'({bus_a.rd_data[0] | bus_a.rd_data[1], bus_a.rd_busy}), 0);
      end

      // reset during sweep cycle 10 aborts it
      idle_a();
      fill_a(18, 22);
      bus_a.clr_req = 1;
      step();
      bus_a.clr_req = 0;
      for (int c = 1; c < 10; c++) step();
      chk("mid_clr_busy", 64'(bus_a.clr_busy), 1);
      reset = 0; #1;
      chk("abort_clr_busy", 64'(bus_a.clr_busy), 0);
      #2 reset = 1;
      step();
      chk("abort_idle", 64'(bus_a.clr_busy), 0);
      bus_a.rd_en = 2'b11; bus_a.rd_addr[0] = 20; bus_a.rd_addr[1] = 12; #1;
      chk("abort_x20", 64'(bus_a.rd_data[0]), 0);
      chk("abort_busy", 64'(bus_a.rd_busy), 0);

      // 4-port 64-bit build: write/read x5 and x0
      bus_b.wr_en = 1; bus_b.wr_addr = 5; bus_b.wr_data = 64'hDEADBEEF_CAFEF00D;
      step();
      bus_b.wr_en = 1; bus_b.wr_addr = 0; bus_b.wr_data = 64'h1;
      bus_b.rd_en = 4'b1100; bus_b.rd_addr[3] = 5; bus_b.rd_addr[2] = 0;
      step();
      bus_b.wr_en = 0; #1;
      chk("b_rd_x5", bus_b.rd_data[3], 64'hDEADBEEF_CAFEF00D);
      chk("b_rd_x0", bus_b.rd_data[2], 0);
      chk("b_rd_off", bus_b.rd_data[0], 0);

      $display("test done: total=%0d bad=%0d", n_chk, n_bad);
      $finish;
   end
endmodule
